// File: rtl/demap_pkg.sv
// Shared types, default frame geometry and counter-width helper for the frame demapper.
package demap_pkg;

   typedef enum logic [0:0] {StHunt, StLocked} demap_state_e;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_NUM_ROWS  = 4;
   localparam int unsigned DEF_NUM_COLS  = 1041;
   localparam int unsigned DEF_OH_COLS   = 16;
   localparam int unsigned DEF_STUFF_COL = 1040;
   localparam int unsigned DEF_ARQ_ROW   = 0;
   localparam int unsigned DEF_ARQ_COL   = 6;

   // Never returns 0 so a single-row or single-column geometry still gets a 1-bit counter.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned ROW_W = cnt_w(DEF_NUM_ROWS);
   localparam int unsigned COL_W = cnt_w(DEF_NUM_COLS);

endpackage

// File: rtl/frame_demap_param_if.sv
// Line-side input and payload-side output bundle of the frame demapper.
interface frame_demap_param_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] i_frame_data;
   logic              i_frame_data_valid;
   logic              i_frame_sof;
   logic [DATA_W-1:0] o_pyld_data;
   logic              o_pyld_data_valid;
   logic              o_pyld_sof;
   logic              o_arq_en;
   logic              o_arq_en_valid;
   logic              o_locked;
   logic              o_sof_err;

   modport master (
      output i_frame_data, i_frame_data_valid, i_frame_sof,
      input  o_pyld_data, o_pyld_data_valid, o_pyld_sof, o_arq_en, o_arq_en_valid,
      input  o_locked, o_sof_err
   );

   modport slave (
      input  i_frame_data, i_frame_data_valid, i_frame_sof,
      output o_pyld_data, o_pyld_data_valid, o_pyld_sof, o_arq_en, o_arq_en_valid,
      output o_locked, o_sof_err
   );
endinterface

// File: rtl/demap_pos_cnt.sv
// Row/column position of the current line byte within the frame.
module demap_pos_cnt
   import demap_pkg::*;
#(
   parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
   parameter int unsigned NUM_COLS = DEF_NUM_COLS,
   parameter int unsigned ROW_BITS = cnt_w(NUM_ROWS),
   parameter int unsigned COL_BITS = cnt_w(NUM_COLS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                advance,
   input  logic                load_zero,
   output logic [ROW_BITS-1:0] row,
   output logic [COL_BITS-1:0] col,
   output logic                at_origin
);

   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NUM_ROWS - 1);
   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(NUM_COLS - 1);

   logic [ROW_BITS-1:0] row_base, row_d;
   logic [COL_BITS-1:0] col_base, col_d;

   // load_zero: the current byte is the origin, so step to the position just after it.
   always_comb begin
      row_base = load_zero ? '0 : row;
      col_base = load_zero ? '0 : col;
      row_d    = row_base;
      col_d    = col_base + COL_BITS'(1);
      if (col_base == COL_LAST) begin
         col_d = '0;
         row_d = (row_base == ROW_LAST) ? '0 : row_base + ROW_BITS'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         row <= '0;
         col <= '0;
      end else if (advance || load_zero) begin
         row <= row_d;
         col <= col_d;
      end
   end

   assign at_origin = (row == '0) && (col == '0);

endmodule

// File: rtl/frame_demap_param.sv
// Receive demapper: SOF lock/realign, overhead strip, stuff zeroing, ARQ_EN extraction.
// Define DEMAP_ARQ_VOTE_EN to majority-vote ARQ_EN over all rows instead of one sample.
module frame_demap_param
   import demap_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned NUM_ROWS  = DEF_NUM_ROWS,
   parameter int unsigned NUM_COLS  = DEF_NUM_COLS,
   parameter int unsigned OH_COLS   = DEF_OH_COLS,
   parameter int unsigned STUFF_COL = DEF_STUFF_COL,
   parameter int unsigned ARQ_ROW   = DEF_ARQ_ROW,
   parameter int unsigned ARQ_COL   = DEF_ARQ_COL
) (
   input logic                i_clk,
   input logic                i_rst,
   frame_demap_param_if.slave bus
);

   localparam int unsigned ROW_BITS = cnt_w(NUM_ROWS);
   localparam int unsigned COL_BITS = cnt_w(NUM_COLS);

   demap_state_e        state_q, state_d;
   logic                miss_q, miss_d;
   logic                advance, load_zero, at_origin;
   logic [ROW_BITS-1:0] row, eff_row;
   logic [COL_BITS-1:0] col, eff_col;
   logic                fwd_valid, fwd_sof, sof_err_d, arq_valid_d, arq_en_d;
   logic [DATA_W-1:0]   fwd_data;
   logic [DATA_W-1:0]   pyld_data_q;
   logic                pyld_valid_q, pyld_sof_q, arq_en_q, arq_valid_q, sof_err_q;

`ifdef DEMAP_ARQ_VOTE_EN
   localparam int unsigned VOTE_W = cnt_w(NUM_ROWS + 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NUM_ROWS - 1);
   logic [VOTE_W-1:0] vote_q, vote_d, ones;
`endif

   demap_pos_cnt #(
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS),
      .ROW_BITS (ROW_BITS),
      .COL_BITS (COL_BITS)
   ) u_pos_cnt (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .advance   (advance),
      .load_zero (load_zero),
      .row       (row),
      .col       (col),
      .at_origin (at_origin)
   );

   always_comb begin
      state_d     = state_q;
      miss_d      = miss_q;
      advance     = 1'b0;
      load_zero   = 1'b0;
      sof_err_d   = 1'b0;
      fwd_valid   = 1'b0;
      fwd_sof     = 1'b0;
      fwd_data    = bus.i_frame_data;
      arq_valid_d = 1'b0;
      arq_en_d    = arq_en_q;
      eff_row     = row;
      eff_col     = col;
`ifdef DEMAP_ARQ_VOTE_EN
      vote_d      = vote_q;
      ones        = '0;
`endif
      if (bus.i_frame_data_valid) begin
         unique case (state_q)
            StHunt: begin
               if (bus.i_frame_sof) begin
                  state_d   = StLocked;
                  load_zero = 1'b1;
                  miss_d    = 1'b0;
               end
            end
            StLocked: begin
               advance = 1'b1;
               if (bus.i_frame_sof && !at_origin) begin
                  // Realign: this byte becomes row0/col0, so it is decoded as overhead.
                  load_zero = 1'b1;
                  sof_err_d = 1'b1;
                  miss_d    = 1'b0;
                  eff_row   = '0;
                  eff_col   = '0;
               end else if (bus.i_frame_sof) begin
                  miss_d = 1'b0;
               end else if (at_origin) begin
                  sof_err_d = 1'b1;
                  if (miss_q) begin
                     state_d = StHunt;
                     miss_d  = 1'b0;
                  end else begin
                     miss_d = 1'b1;
                  end
               end

               if (eff_col >= COL_BITS'(OH_COLS)) begin
                  fwd_valid = 1'b1;
                  fwd_sof   = (eff_row == '0) && (eff_col == COL_BITS'(OH_COLS));
                  if (eff_col == COL_BITS'(STUFF_COL)) fwd_data = '0;
               end

`ifdef DEMAP_ARQ_VOTE_EN
               // Row 0 restarts the tally, which also discards any vote cut short by a realign.
               if (eff_col == COL_BITS'(ARQ_COL)) begin
                  ones   = ((eff_row == '0) ? '0 : vote_q) + VOTE_W'(&bus.i_frame_data);
                  vote_d = ones;
                  if (eff_row == ROW_LAST) begin
                     arq_valid_d = 1'b1;
                     arq_en_d    = (32'(ones) << 1) > NUM_ROWS;
                  end
               end
`else
               if (eff_row == ROW_BITS'(ARQ_ROW) && eff_col == COL_BITS'(ARQ_COL)) begin
                  arq_valid_d = 1'b1;
                  arq_en_d    = &bus.i_frame_data;
               end
`endif
            end
            default: state_d = StHunt;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= StHunt;
         miss_q       <= 1'b0;
         pyld_data_q  <= '0;
         pyld_valid_q <= 1'b0;
         pyld_sof_q   <= 1'b0;
         arq_en_q     <= 1'b0;
         arq_valid_q  <= 1'b0;
         sof_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         miss_q       <= miss_d;
         pyld_valid_q <= fwd_valid;
         pyld_sof_q   <= fwd_sof;
         arq_en_q     <= arq_en_d;
         arq_valid_q  <= arq_valid_d;
         sof_err_q    <= sof_err_d;
         if (fwd_valid) pyld_data_q <= fwd_data;
      end
   end

`ifdef DEMAP_ARQ_VOTE_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) vote_q <= '0;
      else       vote_q <= vote_d;
   end
`endif

   assign bus.o_pyld_data       = pyld_data_q;
   assign bus.o_pyld_data_valid = pyld_valid_q;
   assign bus.o_pyld_sof        = pyld_sof_q;
   assign bus.o_arq_en          = arq_en_q;
   assign bus.o_arq_en_valid    = arq_valid_q;
   assign bus.o_sof_err         = sof_err_q;
   assign bus.o_locked          = (state_q == StLocked);

endmodule

// File: tb/tb_frame_demap_param.sv
// Directed bench for frame_demap_param at default geometry (4 x 1041, 16 overhead columns).
module tb_frame_demap_param;

   localparam int NR    = 4;
   localparam int NC    = 1041;
   localparam int OH    = 16;
   localparam int STUFF = 1040;
   localparam int ARQC  = 6;
   localparam int FLEN  = NR * NC;
   localparam int FWD   = NR * (NC - OH);
`ifdef DEMAP_ARQ_VOTE_EN
   localparam int PULSE_ROW = NR - 1;
   localparam bit VOTE      = 1'b1;
`else
   localparam int PULSE_ROW = 0;
   localparam bit VOTE      = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   frame_demap_param_if #(.DATA_W(8)) bus ();

   frame_demap_param #(.DATA_W(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct packed {logic [7:0] d; logic s;} exp_t;
   exp_t exp_q[$];

   int   checks = 0, failures = 0;
   int   cyc = 0, arq_drv_cyc = 0;
   int   n_valid = 0, n_psof = 0, n_arq = 0, n_err = 0, mon_bad = 0, last_arq_cyc = 0;
   logic last_arq_en = 1'b0;
   int   b_valid, b_psof, b_arq, b_err;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every forwarded byte must match the next expected entry.
   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.o_pyld_data_valid) begin
         n_valid <= n_valid + 1;
         if (bus.o_pyld_sof) n_psof <= n_psof + 1;
         if (exp_q.size() == 0) mon_bad <= mon_bad + 1;
         else begin
            e = exp_q.pop_front();
            if (e.d !== bus.o_pyld_data || e.s !== bus.o_pyld_sof) mon_bad <= mon_bad + 1;
         end
      end else if (bus.o_pyld_sof) begin
         mon_bad <= mon_bad + 1;
      end
      if (bus.o_arq_en_valid) begin
         n_arq        <= n_arq + 1;
         last_arq_en  <= bus.o_arq_en;
         last_arq_cyc <= cyc;
      end
      if (bus.o_sof_err) n_err <= n_err + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] pat(input int r, input int c);
      return 8'(r * 37 + c * 5 + 3);
   endfunction

   task automatic put(input logic [7:0] d, input logic v, input logic s);
      @(negedge clk);
      bus.i_frame_data       = d;
      bus.i_frame_data_valid = v;
      bus.i_frame_sof        = s;
   endtask

   task automatic settle();
      put(8'h00, 1'b0, 1'b0);
      put(8'h00, 1'b0, 1'b0);
      #1;
   endtask

   task automatic snap();
      b_valid = n_valid;
      b_psof  = n_psof;
      b_arq   = n_arq;
      b_err   = n_err;
   endtask

   // Send frame positions first..last; arq[r] is the byte placed at (r, ARQC).
   task automatic run(input int first, input int last, input bit sof0, input bit fwd,
                      input bit gap, input logic [3:0][7:0] arq);
      for (int p = first; p <= last; p++) begin
         int r, c;
         logic [7:0] d;
         r = p / NC;
         c = p % NC;
         d = (c == ARQC) ? arq[r] : pat(r, c);
         if (fwd && c >= OH) exp_q.push_back('{d: (c == STUFF) ? 8'h00 : d, s: (r == 0 && c == OH)});
         put(d, 1'b1, sof0 && p == 0);
         if (c == ARQC && r == PULSE_ROW) arq_drv_cyc = cyc;
         if (gap) put(8'hA5, 1'b0, 1'b1);
      end
   endtask

   task automatic expect_counts(input string tag, input int v, input int ps, input int a,
                                input int e);
      chk({tag, "_valid"}, n_valid - b_valid, v);
      chk({tag, "_psof"}, n_psof - b_psof, ps);
      chk({tag, "_arq"}, n_arq - b_arq, a);
      chk({tag, "_soferr"}, n_err - b_err, e);
      chk({tag, "_data"}, mon_bad, 0);
      chk({tag, "_qlen"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data"}, int'(bus.o_pyld_data), 0);
      chk({tag, "_valid"}, int'(bus.o_pyld_data_valid), 0);
      chk({tag, "_psof"}, int'(bus.o_pyld_sof), 0);
      chk({tag, "_arq_en"}, int'(bus.o_arq_en), 0);
      chk({tag, "_arq_v"}, int'(bus.o_arq_en_valid), 0);
      chk({tag, "_locked"}, int'(bus.o_locked), 0);
      chk({tag, "_soferr"}, int'(bus.o_sof_err), 0);
   endtask

   initial begin
      bus.i_frame_data       = 8'h00;
      bus.i_frame_data_valid = 1'b0;
      bus.i_frame_sof        = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Three aligned frames, ARQ byte FF / FE / FF.
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF); settle();
      expect_counts("f1", FWD, 1, 1, 0);
      chk("f1_locked", int'(bus.o_locked), 1);
      chk("f1_arq_en", int'(last_arq_en), 1);
      chk("f1_arq_lat", last_arq_cyc - arq_drv_cyc, 1);
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b0, 32'hFEFEFEFE); settle();
      expect_counts("f2", FWD, 1, 1, 0);
      chk("f2_arq_en", int'(last_arq_en), 0);
      chk("f2_arq_lat", last_arq_cyc - arq_drv_cyc, 1);
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF); settle();
      expect_counts("f3", FWD, 1, 1, 0);
      chk("f3_arq_en", int'(last_arq_en), 1);

      // Stray SOF at row2 col500: that byte is dropped and restarts the frame.
      snap();
      run(0, 2 * NC + 500 - 1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
      put(pat(2, 500), 1'b1, 1'b1);
      run(1, FLEN - 1, 1'b0, 1'b1, 1'b0, 32'hFEFEFEFE);
      settle();
      expect_counts("realign", 2 * (NC - OH) + (500 - OH) + FWD, 2, VOTE ? 1 : 2, 1);
      chk("realign_arq_en", int'(last_arq_en), 0);
      chk("realign_locked", int'(bus.o_locked), 1);
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF); settle();
      expect_counts("post_realign", FWD, 1, 1, 0);

      // Two frames without SOF: first stays locked, second drops to hunt.
      snap(); run(0, FLEN - 1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF); settle();
      expect_counts("miss1", FWD, 1, 1, 1);
      chk("miss1_locked", int'(bus.o_locked), 1);
      snap(); run(0, FLEN - 1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
      repeat (3) put(8'h00, 1'b0, 1'b1);
      settle();
      expect_counts("miss2", 0, 0, 0, 1);
      chk("miss2_locked", int'(bus.o_locked), 0);
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF); settle();
      expect_counts("relock", FWD, 1, 1, 0);
      chk("relock_locked", int'(bus.o_locked), 1);

      // Valid toggling every cycle, then reset in the middle of row1.
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF); settle();
      expect_counts("gap", FWD, 1, 1, 0);
      chk("gap_arq_lat", last_arq_cyc - arq_drv_cyc, 1);
      run(0, NC + 700 - 1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
      @(negedge clk);
      rst                    = 1'b1;
      bus.i_frame_data       = pat(1, 700);
      bus.i_frame_data_valid = 1'b1;
      bus.i_frame_sof        = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      rst = 1'b0;
      snap();
      for (int i = 0; i < 20; i++) put(pat(1, 701 + i), 1'b1, 1'b0);
      settle();
      expect_counts("hunt_after_rst", 0, 0, 0, 0);
      chk("hunt_after_rst_locked", int'(bus.o_locked), 0);
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF); settle();
      expect_counts("post_rst", FWD, 1, 1, 0);

      // Per-row ARQ bytes FF,FF,00,FF then FF,00,00,FF.
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b0, 32'hFF00FFFF); settle();
      expect_counts("vote_a", FWD, 1, 1, 0);
      chk("vote_a_arq_en", int'(last_arq_en), 1);
      chk("vote_a_arq_lat", last_arq_cyc - arq_drv_cyc, 1);
      snap(); run(0, FLEN - 1, 1'b1, 1'b1, 1'b0, 32'hFF0000FF); settle();
      expect_counts("vote_b", FWD, 1, 1, 0);
      chk("vote_b_arq_en", int'(last_arq_en), VOTE ? 0 : 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
